// File: rtl/count_tx_serializer.sv
// rtl/count_tx_serializer.sv - captures counter changes and ships them as UART-style serial frames
module count_tx_serializer #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] count_in,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              pend_vld,
    output logic [15:0]       frames_sent,
    output logic [7:0]        overrun_cnt
);
    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        r_state;
    logic [TMR_W-1:0]  r_bit_tmr;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic [15:0]       r_frames_sent;

    logic [DATA_W-1:0] r_last_seen;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_pend_vld;
    logic [7:0]        r_overrun_cnt;

    logic w_change;
    logic w_pop;
    logic w_bit_done;

    assign w_change   = (count_in != r_last_seen);
    assign w_pop      = (r_state == S_IDLE) && r_pend_vld;
    assign w_bit_done = (r_bit_tmr == TMR_LAST);

    // A change on the same edge as a pop refills the buffer without counting as an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_seen   <= '0;
            r_pend_data   <= '0;
            r_pend_vld    <= 1'b0;
            r_overrun_cnt <= 8'd0;
        end else begin
            r_last_seen <= count_in;
            if (w_change) begin
                r_pend_data <= count_in;
                r_pend_vld  <= 1'b1;
                if (r_pend_vld && !w_pop && (r_overrun_cnt != 8'hFF))
                    r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end else if (w_pop) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_bit_tmr     <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_parity      <= 1'b0;
            r_frames_sent <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift   <= r_pend_data;
                        r_parity  <= ^r_pend_data;
                        r_bit_tmr <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_bit_tmr <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_tmr <= r_bit_tmr + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_bit_tmr <= '0;
                        r_shift   <= r_shift >> 1;
                        if (r_bit_idx == IDX_LAST)
                            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        else
                            r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_bit_tmr <= r_bit_tmr + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_bit_tmr <= '0;
                        r_state   <= S_STOP;
                    end else begin
                        r_bit_tmr <= r_bit_tmr + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_bit_tmr     <= '0;
                        r_frames_sent <= r_frames_sent + 16'd1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_bit_tmr <= r_bit_tmr + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line level decodes straight from state so an async reset forces it high at once.
    always_comb begin
        tx_out = 1'b1;
        case (r_state)
            S_START:  tx_out = 1'b0;
            S_DATA:   tx_out = r_shift[0];
            S_PARITY: tx_out = r_parity;
            default:  tx_out = 1'b1;
        endcase
    end

    assign tx_busy     = (r_state != S_IDLE);
    assign pend_vld    = r_pend_vld;
    assign frames_sent = r_frames_sent;
    assign overrun_cnt = r_overrun_cnt;

endmodule
